// File: rtl/roll_display_driver.sv
// Converts a dice roll to BCD via double-dabble and scans it onto a 3-digit 7-segment display.
// Optional macro DISP_LEADING_BLANK_EN blanks leading zero digits (hundreds, then tens).
module roll_display_driver #(
    parameter int unsigned REFRESH_DIV = 1000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  rolled_number,
    input  logic        load,
    output logic        busy,
    output logic [11:0] bcd,
    output logic [6:0]  seg,
    output logic [2:0]  an
);

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        DONE
    } state_t;

    state_t      state_q;
    logic [7:0]  shift_q;
    logic [11:0] scratch_q;
    logic [2:0]  step_q;
    logic [11:0] bcd_q;
    logic [11:0] adjust_d;

    logic [15:0] refresh_q;
    logic [1:0]  digit_q;
    logic [1:0]  digit_d;
    logic        wrap_d;
    logic [11:0] bcd_d;
    logic [3:0]  nibble_d;
    logic        blank_d;
    logic [6:0]  seg_q;
    logic [6:0]  seg_d;
    logic [2:0]  an_q;
    logic [2:0]  an_d;

    // Add 3 to every BCD nibble that is 5 or more before the next shift.
    always_comb begin
        adjust_d = scratch_q;
        if (scratch_q[3:0] >= 4'd5) begin
            adjust_d[3:0] = scratch_q[3:0] + 4'd3;
        end
        if (scratch_q[7:4] >= 4'd5) begin
            adjust_d[7:4] = scratch_q[7:4] + 4'd3;
        end
        if (scratch_q[11:8] >= 4'd5) begin
            adjust_d[11:8] = scratch_q[11:8] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            step_q    <= '0;
            bcd_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load) begin
                        shift_q   <= rolled_number;
                        scratch_q <= '0;
                        step_q    <= '0;
                        state_q   <= CONVERT;
                    end
                end
                CONVERT: begin
                    scratch_q <= {adjust_d[10:0], shift_q[7]};
                    shift_q   <= {shift_q[6:0], 1'b0};
                    step_q    <= step_q + 3'd1;
                    if (step_q == 3'd7) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    bcd_q   <= scratch_q;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state_q != IDLE);
    assign bcd  = bcd_q;

    // Look ahead at next-cycle bcd and digit so seg/an flip on the same edge as the index.
    always_comb begin
        wrap_d  = (refresh_q == 16'(REFRESH_DIV - 1));
        digit_d = digit_q;
        if (wrap_d) begin
            digit_d = (digit_q == 2'd2) ? 2'd0 : digit_q + 2'd1;
        end
        bcd_d = (state_q == DONE) ? scratch_q : bcd_q;

        blank_d = 1'b0;
        case (digit_d)
            2'd1: begin
                nibble_d = bcd_d[7:4];
                an_d     = 3'b101;
`ifdef DISP_LEADING_BLANK_EN
                blank_d  = (bcd_d[11:8] == 4'd0) && (bcd_d[7:4] == 4'd0);
`endif
            end
            2'd2: begin
                nibble_d = bcd_d[11:8];
                an_d     = 3'b011;
`ifdef DISP_LEADING_BLANK_EN
                blank_d  = (bcd_d[11:8] == 4'd0);
`endif
            end
            default: begin
                nibble_d = bcd_d[3:0];
                an_d     = 3'b110;
            end
        endcase

        case (nibble_d)
            4'd0:    seg_d = 7'h40;
            4'd1:    seg_d = 7'h79;
            4'd2:    seg_d = 7'h24;
            4'd3:    seg_d = 7'h30;
            4'd4:    seg_d = 7'h19;
            4'd5:    seg_d = 7'h12;
            4'd6:    seg_d = 7'h02;
            4'd7:    seg_d = 7'h78;
            4'd8:    seg_d = 7'h00;
            4'd9:    seg_d = 7'h10;
            default: seg_d = 7'h7F;
        endcase
        if (blank_d) begin
            seg_d = 7'h7F;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            refresh_q <= '0;
            digit_q   <= '0;
            an_q      <= 3'b110;
            seg_q     <= 7'h40;
        end else begin
            refresh_q <= wrap_d ? 16'd0 : refresh_q + 16'd1;
            digit_q   <= digit_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule

// File: tb/tb_roll_display_driver.sv
// Directed self-checking bench for roll_display_driver: reset, conversion, busy reject, scan, blanking.
module tb_roll_display_driver;

    logic        clk;
    logic        reset_n;
    logic [7:0]  rolled_number;
    logic        load;
    logic        busy;
    logic [11:0] bcd;
    logic [6:0]  seg;
    logic [2:0]  an;

    int totalChecks = 0;
    int badChecks   = 0;

    roll_display_driver #(.REFRESH_DIV(4)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .rolled_number (rolled_number),
        .load          (load),
        .busy          (busy),
        .bcd           (bcd),
        .seg           (seg),
        .an            (an)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0h want %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load a value, count busy cycles (bounded) and check the final BCD.
    task automatic applyStimulus(input logic [7:0] value, input logic [11:0] expBcd, input string tag);
        int busyCycles;
        tick();
        rolled_number = value;
        load = 1'b1;
        tick();
        load = 1'b0;
        busyCycles = 0;
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            busyCycles++;
            tick();
        end
        checkOutput({tag, "_busy"}, 32'(busyCycles), 32'd9);
        checkOutput({tag, "_bcd"}, 32'(bcd), 32'(expBcd));
    endtask

    function automatic logic [2:0] nextAn(input logic [2:0] cur);
        case (cur)
            3'b110:  return 3'b101;
            3'b101:  return 3'b011;
            default: return 3'b110;
        endcase
    endfunction

    initial begin
        logic [2:0] curAn;
        logic [2:0] prevAn;
        logic [6:0] expSeg;
        logic       changed;

        clk = 1'b0;
        reset_n = 1'b1;
        load = 1'b0;
        rolled_number = 8'd0;

        #1 reset_n = 1'b0;
        #2;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_bcd",  32'(bcd),  32'h000);
        checkOutput("rst_an",   32'(an),   32'b110);
        checkOutput("rst_seg",  32'(seg),  32'h40);
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;

        applyStimulus(8'd255, 12'h255, "conv255");
        applyStimulus(8'd0,   12'h000, "conv0");
        applyStimulus(8'd9,   12'h009, "conv9");
        applyStimulus(8'd10,  12'h010, "conv10");
        applyStimulus(8'd99,  12'h099, "conv99");
        applyStimulus(8'd100, 12'h100, "conv100");
        applyStimulus(8'd128, 12'h128, "conv128");

        // Busy reject: 42 accepted, 200 ignored at E4 and E9, accepted at E10.
        tick();
        rolled_number = 8'd42;
        load = 1'b1;
        tick();
        load = 1'b0;
        repeat (3) tick();
        rolled_number = 8'd200;
        load = 1'b1;
        tick();
        load = 1'b0;
        repeat (4) tick();
        load = 1'b1;
        tick();
        load = 1'b0;
        checkOutput("rej_bcd_e9", 32'(bcd), 32'h042);
        checkOutput("rej_busy_e9", 32'(busy), 32'd0);
        load = 1'b1;
        tick();
        load = 1'b0;
        checkOutput("rej_busy_e10", 32'(busy), 32'd1);
        repeat (8) tick();
        checkOutput("rej_bcd_hold", 32'(bcd), 32'h042);
        tick();
        checkOutput("rej_bcd_e19", 32'(bcd), 32'h200);

        // Scan of 123: digits rotate every 4 cycles.
        applyStimulus(8'd123, 12'h123, "conv123");
        prevAn = an;
        changed = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (an != prevAn) begin
                changed = 1'b1;
                break;
            end
        end
        checkOutput("scan_align", 32'(changed), 32'd1);
        for (int k = 0; k < 6; k++) begin
            curAn = an;
            if (k > 0) checkOutput("scan_order", 32'(curAn), 32'(nextAn(prevAn)));
            case (curAn)
                3'b110:  expSeg = 7'h30;
                3'b101:  expSeg = 7'h24;
                3'b011:  expSeg = 7'h79;
                default: expSeg = 7'h7F;
            endcase
            checkOutput("scan_seg", 32'(seg), 32'(expSeg));
            repeat (3) tick();
            checkOutput("scan_hold", 32'(an), 32'(curAn));
            tick();
            prevAn = curAn;
        end

        // Leading-zero display of 7.
        applyStimulus(8'd7, 12'h007, "conv7");
        for (int i = 0; i < 12; i++) begin
            case (an)
                3'b110: expSeg = 7'h78;
`ifdef DISP_LEADING_BLANK_EN
                3'b101, 3'b011: expSeg = 7'h7F;
`else
                3'b101, 3'b011: expSeg = 7'h40;
`endif
                default: expSeg = 7'h00;
            endcase
            checkOutput("blank_seg", 32'(seg), 32'(expSeg));
            tick();
        end

        // Reset in the middle of converting 255.
        tick();
        rolled_number = 8'd255;
        load = 1'b1;
        tick();
        load = 1'b0;
        repeat (4) tick();
        #2 reset_n = 1'b0;
        #1;
        checkOutput("mid_busy", 32'(busy), 32'd0);
        checkOutput("mid_bcd",  32'(bcd),  32'h000);
        checkOutput("mid_an",   32'(an),   32'b110);
        checkOutput("mid_seg",  32'(seg),  32'h40);
        repeat (2) tick();
        #2 reset_n = 1'b1;
        repeat (10) tick();
        checkOutput("mid_bcd_after", 32'(bcd), 32'h000);
        checkOutput("mid_busy_after", 32'(busy), 32'd0);
        applyStimulus(8'd6, 12'h006, "conv6");

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
